// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared encodings for the multi-cycle controller.
// Revision : 1.0
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'd0,
    S_F0    = 5'd1,
    S_F1    = 5'd2,
    S_F2    = 5'd3,
    S_DEC   = 5'd4,
    S_EXA   = 5'd5,
    S_EXI   = 5'd6,
    S_WB    = 5'd7,
    S_MA    = 5'd8,
    S_MR    = 5'd9,
    S_ML    = 5'd10,
    S_MW    = 5'd11,
    S_BR    = 5'd12,
    S_BT    = 5'd13,
    S_HLT   = 5'd14,
    S_FAULT = 5'd15
  } state_e;

  localparam logic [1:0] CLS_ALU_RR  = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM     = 2'b10;
  localparam logic [1:0] CLS_BR      = 2'b11;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_Z      = 2'b01;
  localparam logic [1:0] BR_N      = 2'b10;
  localparam logic [1:0] BR_C      = 2'b11;

  localparam logic [1:0] INREG_NONE = 2'd0;
  localparam logic [1:0] INREG_REG  = 2'd1;
  localparam logic [1:0] INREG_IMM  = 2'd2;
  localparam logic [1:0] INREG_LOAD = 2'd3;

  localparam logic [2:0] ALU_NOP_DEF = 3'b101;

  // flags are packed {Z,N,C}
  function automatic logic br_taken(input logic [1:0] cond, input logic [2:0] flags);
    logic taken;
    case (cond)
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = flags[2];
      BR_N:      taken = flags[1];
      default:   taken = flags[0];
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_wait_timer
// Brief    : Memory-wait cycle counter with clear, enable and timeout flag.
// Revision : 1.0
// ============================================================================
module mc_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle on which one more idle wait would reach TIMEOUT, so a
  // wait state lasts at most TIMEOUT cycles before the controller faults.
  assign timeout = (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multi-cycle controller for the accumulator/temp datapath.
// Revision : 1.0
// ============================================================================
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int                 OPC_W   = 7,
  parameter int                 ALUOP_W = 3,
  parameter int                 TIMEOUT = 15,
  parameter logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(ALU_NOP_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [2:0]         flags,
  input  logic               mem_rdy,
  output logic               wpc,
  output logic               rpc,
  output logic               rm,
  output logic               wmem,
  output logic               wmar,
  output logic               rmar,
  output logic               wmdr,
  output logic               rmdr,
  output logic               wir,
  output logic               wReg,
  output logic               rReg,
  output logic               wt,
  output logic               rt,
  output logic               rc1,
  output logic               ldF,
  output logic [1:0]         inReg,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [4:0]         state,
  output logic               fault
);

  state_e state_q;
  state_e state_d;

  logic [1:0] opc_cls;
  logic       is_halt;
  logic       is_store;
  logic       in_wait;
  logic       wait_tmo;
  logic       mem_expired;

  assign opc_cls  = opcode[OPC_W-1:OPC_W-2];
  assign is_halt  = &opcode;
  assign is_store = opcode[0];

  // Counter is held clear outside the wait states, so every entry starts at 0.
  assign in_wait     = (state_q == S_F1) || (state_q == S_MR) || (state_q == S_MW);
  assign mem_expired = wait_tmo && !mem_rdy;

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_wait),
    .en      (in_wait && !mem_rdy),
    .timeout (wait_tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1: begin
        if (mem_rdy)          state_d = S_F2;
        else if (mem_expired) state_d = S_FAULT;
      end
      S_F2:    state_d = S_DEC;
      S_DEC: begin
        if (is_halt) begin
          state_d = S_HLT;
        end else begin
          case (opc_cls)
            CLS_ALU_RR:  state_d = S_EXA;
            CLS_ALU_IMM: state_d = S_EXI;
            CLS_MEM:     state_d = S_MA;
            default:     state_d = S_BR;
          endcase
        end
      end
      S_EXA:   state_d = S_WB;
      S_EXI:   state_d = S_WB;
      S_WB:    state_d = S_F0;
      S_MA:    state_d = is_store ? S_MW : S_MR;
      S_MR: begin
        if (mem_rdy)          state_d = S_ML;
        else if (mem_expired) state_d = S_FAULT;
      end
      S_ML:    state_d = S_F0;
      S_MW: begin
        if (mem_rdy)          state_d = S_F0;
        else if (mem_expired) state_d = S_FAULT;
      end
      S_BR:    state_d = br_taken(opcode[1:0], flags) ? S_BT : S_F0;
      S_BT:    state_d = S_F0;
      S_HLT:   state_d = S_HLT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Strobes decode the state register; wmdr in the read waits additionally
  // qualifies on mem_rdy so MDR captures only the completing beat.
  always_comb begin
    wpc   = 1'b0;
    rpc   = 1'b0;
    rm    = 1'b0;
    wmem  = 1'b0;
    wmar  = 1'b0;
    rmar  = 1'b0;
    wmdr  = 1'b0;
    rmdr  = 1'b0;
    wir   = 1'b0;
    wReg  = 1'b0;
    rReg  = 1'b0;
    wt    = 1'b0;
    rt    = 1'b0;
    rc1   = 1'b0;
    ldF   = 1'b0;
    inReg = INREG_NONE;
    aluOp = ALU_NOP;
    fault = 1'b0;
    case (state_q)
      S_F0: begin
        rpc  = 1'b1;
        wmar = 1'b1;
      end
      S_F1, S_MR: begin
        rmar = 1'b1;
        rm   = 1'b1;
        wmdr = mem_rdy;
      end
      S_F2: begin
        rmdr = 1'b1;
        wir  = 1'b1;
        rc1  = 1'b1;
        wpc  = 1'b1;
      end
      S_EXA: begin
        rReg  = 1'b1;
        inReg = INREG_REG;
        wt    = 1'b1;
        aluOp = opcode[ALUOP_W-1:0];
      end
      S_EXI: begin
        rmdr  = 1'b1;
        inReg = INREG_IMM;
        wt    = 1'b1;
        aluOp = opcode[ALUOP_W-1:0];
      end
      S_WB: begin
        rt   = 1'b1;
        wReg = 1'b1;
        ldF  = 1'b1;
      end
      S_MA: begin
        rReg  = 1'b1;
        inReg = INREG_REG;
        wmar  = 1'b1;
      end
      S_ML: begin
        rmdr  = 1'b1;
        inReg = INREG_LOAD;
        wReg  = 1'b1;
      end
      S_MW: begin
        rmar = 1'b1;
        rReg = 1'b1;
        wmdr = 1'b1;
        wmem = 1'b1;
      end
      S_BT: begin
        rmdr = 1'b1;
        wpc  = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Directed scoreboard bench for mc_ctrl_fsm.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam logic [14:0] WPC  = 15'h4000;
  localparam logic [14:0] RPC  = 15'h2000;
  localparam logic [14:0] RM   = 15'h1000;
  localparam logic [14:0] WMEM = 15'h0800;
  localparam logic [14:0] WMAR = 15'h0400;
  localparam logic [14:0] RMAR = 15'h0200;
  localparam logic [14:0] WMDR = 15'h0100;
  localparam logic [14:0] RMDR = 15'h0080;
  localparam logic [14:0] WIR  = 15'h0040;
  localparam logic [14:0] WREG = 15'h0020;
  localparam logic [14:0] RREG = 15'h0010;
  localparam logic [14:0] WT   = 15'h0008;
  localparam logic [14:0] RT   = 15'h0004;
  localparam logic [14:0] RC1  = 15'h0002;
  localparam logic [14:0] LDF  = 15'h0001;

  logic       clk = 1'b0;
  logic       rst, run, mem_rdy;
  logic [6:0] opcode;
  logic [2:0] flags;
  logic       wpc, rpc, rm, wmem, wmar, rmar, wmdr, rmdr, wir;
  logic       wReg, rReg, wt, rt, rc1, ldF, fault;
  logic [1:0] inReg;
  logic [2:0] aluOp;
  logic [4:0] state;

  typedef struct {
    string       tag;
    logic [25:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .OPC_W   (7),
    .ALUOP_W (3),
    .TIMEOUT (15),
    .ALU_NOP (3'b101)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .flags(flags), .mem_rdy(mem_rdy),
    .wpc(wpc), .rpc(rpc), .rm(rm), .wmem(wmem), .wmar(wmar), .rmar(rmar), .wmdr(wmdr),
    .rmdr(rmdr), .wir(wir), .wReg(wReg), .rReg(rReg), .wt(wt), .rt(rt), .rc1(rc1),
    .ldF(ldF), .inReg(inReg), .aluOp(aluOp), .state(state), .fault(fault)
  );

  // One clock: drive inputs, queue the expected outputs of the current
  // state, compare on the falling edge, then advance past the rising edge.
  task automatic cyc(input string tag, input bit r, input bit rn, input bit rdy,
                     input state_e st, input logic [14:0] sb,
                     input logic [1:0] ir = 2'd0, input logic [2:0] alu = 3'b101,
                     input bit flt = 1'b0);
    exp_t        e;
    logic [25:0] obs;
    rst     = r;
    run     = rn;
    mem_rdy = rdy;
    e.tag   = tag;
    e.exp   = {st, flt, alu, ir, sb};
    q.push_back(e);
    @(negedge clk);
    e   = q.pop_front();
    obs = {state, fault, aluOp, inReg, wpc, rpc, rm, wmem, wmar, rmar, wmdr,
           rmdr, wir, wReg, rReg, wt, rt, rc1, ldF};
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; opcode = 7'd0; flags = 3'd0;
    @(posedge clk);
    #1;

    // Reset and idle; mem_rdy is ignored outside wait states
    cyc("rst_hold", 1, 0, 0, S_IDLE, 15'd0);
    for (int i = 0; i < 5; i++) cyc("idle", 0, 0, 1, S_IDLE, 15'd0);

    // ALU reg-reg, zero-wait memory; run held high later is ignored
    opcode = 7'b0000011;
    cyc("alu_idle_run", 0, 1, 1, S_IDLE, 15'd0);
    cyc("alu_f0",       0, 0, 1, S_F0,   RPC | WMAR);
    cyc("alu_f1",       0, 0, 1, S_F1,   RMAR | RM | WMDR);
    cyc("alu_f2",       0, 0, 1, S_F2,   RMDR | WIR | RC1 | WPC);
    cyc("alu_dec",      0, 0, 1, S_DEC,  15'd0);
    cyc("alu_exa",      0, 0, 1, S_EXA,  RREG | WT, INREG_REG, 3'b011);
    cyc("alu_wb",       0, 1, 1, S_WB,   RT | WREG | LDF);
    cyc("alu_f0_next",  0, 0, 1, S_F0,   RPC | WMAR);

    // Load with three wait cycles in MR
    opcode = 7'b1000000;
    cyc("ld_f1",  0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("ld_f2",  0, 0, 1, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("ld_dec", 0, 0, 1, S_DEC, 15'd0);
    cyc("ld_ma",  0, 0, 0, S_MA,  RREG | WMAR, INREG_REG);
    for (int i = 0; i < 3; i++) cyc("ld_mr_wait", 0, 0, 0, S_MR, RMAR | RM);
    cyc("ld_mr_rdy", 0, 0, 1, S_MR, RMAR | RM | WMDR);
    cyc("ld_ml",     0, 0, 1, S_ML, RMDR | WREG, INREG_LOAD);
    cyc("ld_f0",     0, 0, 1, S_F0, RPC | WMAR);

    // ALU immediate
    opcode = 7'b0100110;
    cyc("imm_f1",  0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("imm_f2",  0, 0, 1, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("imm_dec", 0, 0, 1, S_DEC, 15'd0);
    cyc("imm_exi", 0, 0, 1, S_EXI, RMDR | WT, INREG_IMM, 3'b110);
    cyc("imm_wb",  0, 0, 1, S_WB,  RT | WREG | LDF);
    cyc("imm_f0",  0, 0, 1, S_F0,  RPC | WMAR);

    // Store with one wait cycle
    opcode = 7'b1000001;
    cyc("st_f1",      0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("st_f2",      0, 0, 1, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("st_dec",     0, 0, 1, S_DEC, 15'd0);
    cyc("st_ma",      0, 0, 0, S_MA,  RREG | WMAR, INREG_REG);
    cyc("st_mw_wait", 0, 0, 0, S_MW,  RMAR | RREG | WMDR | WMEM);
    cyc("st_mw_rdy",  0, 0, 1, S_MW,  RMAR | RREG | WMDR | WMEM);
    cyc("st_f0",      0, 0, 1, S_F0,  RPC | WMAR);

    // Branch on Z: taken, then not taken with N and C set
    opcode = 7'b1100001;
    flags  = 3'b100;
    cyc("bz_f1",  0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("bz_f2",  0, 0, 1, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("bz_dec", 0, 0, 1, S_DEC, 15'd0);
    cyc("bz_br",  0, 0, 1, S_BR,  15'd0);
    cyc("bz_bt",  0, 0, 1, S_BT,  RMDR | WPC);
    cyc("bz_f0",  0, 0, 1, S_F0,  RPC | WMAR);
    flags  = 3'b011;
    cyc("bnz_f1",  0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("bnz_f2",  0, 0, 1, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("bnz_dec", 0, 0, 1, S_DEC, 15'd0);
    cyc("bnz_br",  0, 0, 1, S_BR,  15'd0);
    cyc("bnz_f0",  0, 0, 1, S_F0,  RPC | WMAR);

    // HALT is sticky until reset
    opcode = 7'b1111111;
    cyc("hlt_f1",   0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("hlt_f2",   0, 0, 1, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("hlt_dec",  0, 0, 1, S_DEC, 15'd0);
    cyc("hlt_0",    0, 1, 1, S_HLT, 15'd0);
    cyc("hlt_1",    0, 1, 1, S_HLT, 15'd0);
    cyc("hlt_rst",  1, 0, 0, S_HLT, 15'd0);
    cyc("hlt_idle", 0, 0, 0, S_IDLE, 15'd0);

    // Fetch timeout: 15 idle wait cycles in F1, then FAULT
    opcode = 7'b0000011;
    cyc("to_idle_run", 0, 1, 0, S_IDLE, 15'd0);
    cyc("to_f0",       0, 0, 0, S_F0,   RPC | WMAR);
    for (int i = 0; i < 15; i++) cyc("to_f1_wait", 0, 0, 0, S_F1, RMAR | RM);
    cyc("to_fault_0",    0, 1, 1, S_FAULT, 15'd0, INREG_NONE, 3'b101, 1'b1);
    cyc("to_fault_1",    0, 0, 0, S_FAULT, 15'd0, INREG_NONE, 3'b101, 1'b1);
    cyc("to_fault_rst",  1, 0, 0, S_FAULT, 15'd0, INREG_NONE, 3'b101, 1'b1);
    cyc("to_idle_clear", 0, 0, 0, S_IDLE,  15'd0);

    // mem_rdy on the last allowed wait cycle wins over the timeout
    opcode = 7'b1000001;
    cyc("race_idle_run", 0, 1, 0, S_IDLE, 15'd0);
    cyc("race_f0",       0, 0, 0, S_F0,   RPC | WMAR);
    for (int i = 0; i < 14; i++) cyc("race_f1_wait", 0, 0, 0, S_F1, RMAR | RM);
    cyc("race_f1_rdy", 0, 0, 1, S_F1,  RMAR | RM | WMDR);
    cyc("race_f2",     0, 0, 0, S_F2,  RMDR | WIR | RC1 | WPC);
    cyc("race_dec",    0, 0, 0, S_DEC, 15'd0);
    cyc("race_ma",     0, 0, 0, S_MA,  RREG | WMAR, INREG_REG);

    // Reset mid-store wait
    cyc("mw_wait",   0, 0, 0, S_MW,   RMAR | RREG | WMDR | WMEM);
    cyc("mw_rst",    1, 0, 0, S_MW,   RMAR | RREG | WMDR | WMEM);
    cyc("mw_idle",   0, 0, 1, S_IDLE, 15'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multi-cycle control unit for the accumulator/temp-register datapath; successor to the combinational controller that took its state in from outside.
- Owns its state register.
- Decodes a variable-width opcode.
- Waits on a memory-ready handshake with a timeout watchdog.
- Evaluates branch conditions from datapath flags.
- Drives every datapath strobe as a Moore output of the current state.

Parameters:
- OPC_W, 7, opcode width (>=5).
- ALUOP_W, 3, aluOp width.
- TIMEOUT, 15, max cycles waiting for mem_rdy before FAULT (1..255).
- ALU_NOP, 3'b101, aluOp value driven when the ALU is idle.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous, active-high reset.
- run, in, 1, leave IDLE and start fetching.
- opcode, in, OPC_W, instruction opcode from the IR (valid from DECODE onward).
- flags, in, 3, {Z,N,C} from the flag register.
- mem_rdy, in, 1, memory completes the current read or write this cycle.
- wpc, rpc, rm, wmem, wmar, rmar, wmdr, rmdr, wir, wReg, rReg, wt, rt, rc1, ldF, out, 1 each, datapath strobes.
- inReg, out, 2, register-file source select.
- aluOp, out, ALUOP_W, ALU function.
- state, out, 5, current state (debug).
- fault, out, 1, sticky memory-timeout indicator.

Behaviour:
- Reset: on clk with rst=1:
  - state=IDLE, wait counter=0, fault=0.
  - All strobes 0, inReg=0, aluOp=ALU_NOP.
  - rst has priority over every transition, including mid-wait.
- Outputs are a pure decode of the state register: they are valid the cycle the state is entered. Any strobe not listed for a state is 0; aluOp is ALU_NOP unless listed.
- Opcode classes, from opcode[OPC_W-1:OPC_W-2]:
  - 00 ALU reg-reg.
  - 01 ALU immediate.
  - 10 memory; opcode[0]=1 is a store.
  - 11 branch; condition is opcode[1:0]: 00 always, 01 Z, 10 N, 11 C.
  - The ALU function is opcode[ALUOP_W-1:0].
  - opcode of all-ones is HALT.
- States and transitions:
  - IDLE: no strobes. Goes to F0 when run=1.
  - F0: rpc, wmar. Goes to F1.
  - F1: rmar, rm. Waits for mem_rdy; on mem_rdy asserts wmdr and goes to F2.
  - F2: rmdr, wir, rc1, wpc (PC+1). Goes to DEC.
  - DEC: no strobes. Routes by class:
    - HALT opcode goes to HLT.
    - ALU reg-reg goes to EXA.
    - ALU immediate goes to EXI.
    - Memory goes to MA.
    - Branch goes to BR.
  - EXA: rReg, inReg=1, wt, aluOp=func. Goes to WB.
  - EXI: rmdr, inReg=2, wt, aluOp=func. Goes to WB.
  - WB: rt, wReg, ldF. Goes to F0.
  - MA: rReg, inReg=1, wmar. Goes to MR for a load, or MW for a store.
  - MR: rmar, rm. Waits for mem_rdy; on mem_rdy asserts wmdr and goes to ML.
  - ML: rmdr, inReg=3, wReg. Goes to F0.
  - MW: rmar, rReg, wmdr, wmem. Waits for mem_rdy, then goes to F0.
  - BR: no strobes. Goes to BT if the condition is true, otherwise F0.
  - BT: rmdr, wpc. Goes to F0.
  - HLT: no strobes. Stays until rst.
  - FAULT: no strobes, fault=1. Stays until rst.
- Wait counter:
  - Clears on entry to F1, MR or MW.
  - Increments each cycle in one of those states while mem_rdy=0.
  - When counter reaches TIMEOUT with mem_rdy still 0, the next state is FAULT.
  - If mem_rdy=1 arrives on that same cycle, mem_rdy wins and the FSM proceeds normally.
- mem_rdy outside F1/MR/MW is ignored. run is ignored outside IDLE.
- mem_rdy already high on entry to a wait state completes in one cycle. Minimum instruction lengths:
  - ALU: 6 cycles.
  - Load: 7 cycles.
  - Store: 6 cycles.
  - Branch taken: 6 cycles; not taken: 5 cycles.
- Unlisted state encodings go to FAULT.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the 5-bit state encodings;
  - opcode class constants;
  - branch condition codes;
  - the inReg source codes (1 register, 2 MDR immediate, 3 MDR load);
  - the ALU_NOP default.
- One sub-module, mc_wait_timer: the wait counter with clear, enable, and timeout-flag outputs.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then run=0 for 5 cycles -> state=IDLE, all strobes 0, aluOp=3'b101, fault=0.
2. ALU reg-reg with zero-wait memory: run=1, mem_rdy=1, opcode=7'b0000011 -> state sequence F0,F1,F2,DEC,EXA,WB,F0; aluOp=3'b011 in EXA; wReg and ldF high in WB only.
3. Load with 3 wait cycles: opcode=7'b1000000, mem_rdy low for 3 cycles in MR -> MR held 4 cycles, wmdr high only on the rdy cycle, then ML with inReg=3 and wReg=1.
4. Branch: flags Z=1 with opcode=7'b1100001 -> BR then BT, wpc=1. Then flags Z=0 with the same opcode -> BR then F0.
5. Timeout: mem_rdy held 0 in F1 -> after 15 wait cycles state=FAULT, fault=1. rst then clears fault and state returns to IDLE.
6. Timeout race and mid-operation reset: mem_rdy=1 exactly on the TIMEOUT cycle -> proceeds to F2, no fault. Separately, rst asserted during MW -> next cycle state=IDLE, wmem=0.
